multicycle_controller: RTL and testbench

- Control FSM for the multicycle variant of the RV32I core.
- Consumes OP, funct3, funct7 (Instr[30]) and Zero from the multicycle datapath. Drives that datapath's mux selects, write strobes and ALUControl.
- One instruction executes over 3–5 cycles.
- Supported instructions: lw, sw, R-type ALU (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq, jal.

---
 rtl/multicycle_controller.sv | 204 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: sequences fetch/decode/execute/writeback over 3-5 cycles.
// Optional feature macro: INSTRET_COUNTER_EN adds the retired-instruction counter output InstRet.
module multicycle_controller #(
    parameter bit          ILLEGAL_HALT  = 1'b1,
    parameter int unsigned COUNTER_WIDTH = 32
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       EN,
    input  logic [6:0] OP,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [2:0] ALUControl,
    output logic       Halted
`ifdef INSTRET_COUNTER_EN
    ,
    output logic [COUNTER_WIDTH-1:0] InstRet
`endif
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_HALT
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    state_t  state;
    alu_op_t alu_op;
    logic    pc_update, branch, ir_write, mem_write, reg_write, active;

    // State register; a stall simply holds the current state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= S_FETCH;
        end else if (EN) begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    case (OP)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_R:         state <= S_EXECUTER;
                        OP_I:         state <= S_EXECUTEI;
                        OP_BEQ:       state <= S_BEQ;
                        OP_JAL:       state <= S_JAL;
                        default:      state <= ILLEGAL_HALT ? S_HALT : S_FETCH;
                    endcase
                end
                S_MEMADR:   state <= OP[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  state <= S_MEMWB;
                S_EXECUTER: state <= S_ALUWB;
                S_EXECUTEI: state <= S_ALUWB;
                S_JAL:      state <= S_ALUWB;
                S_HALT:     state <= S_HALT;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // Moore decode of selects and raw strobes.
    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        ir_write  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = ALU_ADD;
        Halted    = 1'b0;
        case (state)
            S_FETCH: begin
                ir_write  = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_update = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = ALU_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = ALU_FUNCT;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = ALU_SUB;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            S_HALT:  Halted = 1'b1;
            default: ;
        endcase
    end

    // Strobes are suppressed while stalled or held in reset.
    assign active   = EN & ~RESET;
    assign PCWrite  = active & (pc_update | (branch & Zero));
    assign IRWrite  = active & ir_write;
    assign MemWrite = active & mem_write;
    assign RegWrite = active & reg_write;

    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            ALU_SUB: ALUControl = 3'b001;
            ALU_FUNCT: begin
                case (funct3)
                    3'b000:  ALUControl = (OP[5] & funct7) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        case (OP)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

`ifdef INSTRET_COUNTER_EN
    logic known_op, retire;

    // Retire on every final state heading back to FETCH, plus an illegal opcode taken as NOP.
    always_comb begin
        known_op = (OP == OP_LW) || (OP == OP_SW) || (OP == OP_R) ||
                   (OP == OP_I) || (OP == OP_BEQ) || (OP == OP_JAL);
        retire = 1'b0;
        case (state)
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: retire = 1'b1;
            S_DECODE: retire = !ILLEGAL_HALT && !known_op;
            default:  retire = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            InstRet <= '0;
        end else if (EN && retire) begin
            InstRet <= InstRet + COUNTER_WIDTH'(1);
        end
    end
`else
    logic unused_counter_width;
    assign unused_counter_width = ^COUNTER_WIDTH;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller; runs a halting and a NOP-on-illegal instance side by side.
module tb_multicycle_controller;

    logic       CLK, RESET, EN, funct7, Zero;
    logic [6:0] OP;
    logic [2:0] funct3;

    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Halted;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    logic       n_PCWrite, n_AdrSrc, n_MemWrite, n_IRWrite, n_RegWrite, n_Halted;
    logic [1:0] n_ResultSrc, n_ALUSrcA, n_ALUSrcB, n_ImmSrc;
    logic [2:0] n_ALUControl;
`ifdef INSTRET_COUNTER_EN
    logic [31:0] InstRet, n_InstRet;
`endif

    multicycle_controller #(.ILLEGAL_HALT(1'b1), .COUNTER_WIDTH(32)) dut (
        .CLK(CLK), .RESET(RESET), .EN(EN), .OP(OP), .funct3(funct3), .funct7(funct7), .Zero(Zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .RegWrite(RegWrite), .ALUControl(ALUControl), .Halted(Halted)
`ifdef INSTRET_COUNTER_EN
        , .InstRet(InstRet)
`endif
    );

    multicycle_controller #(.ILLEGAL_HALT(1'b0), .COUNTER_WIDTH(32)) dut_nop (
        .CLK(CLK), .RESET(RESET), .EN(EN), .OP(OP), .funct3(funct3), .funct7(funct7), .Zero(Zero),
        .PCWrite(n_PCWrite), .AdrSrc(n_AdrSrc), .MemWrite(n_MemWrite), .IRWrite(n_IRWrite),
        .ResultSrc(n_ResultSrc), .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB), .ImmSrc(n_ImmSrc),
        .RegWrite(n_RegWrite), .ALUControl(n_ALUControl), .Halted(n_Halted)
`ifdef INSTRET_COUNTER_EN
        , .InstRet(n_InstRet)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks, n_bad, lat, n_rw, n_mw, n_pcw, ret_exp;
    logic [2:0] s_alc [16];
    logic [1:0] s_rs [16];
    logic [1:0] s_sa [16];
    logic [1:0] s_sb [16];
    logic       s_adr [16];
    logic       s_rw [16];
    logic       s_mw [16];
    logic       s_pcw [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic snap(input int k);
        s_alc[k] = ALUControl;
        s_rs[k]  = ResultSrc;
        s_sa[k]  = ALUSrcA;
        s_sb[k]  = ALUSrcB;
        s_adr[k] = AdrSrc;
        s_rw[k]  = RegWrite;
        s_mw[k]  = MemWrite;
        s_pcw[k] = PCWrite;
    endtask

    // Starts in FETCH; steps until the next FETCH (bounded), snapshotting every cycle.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
        OP = op; funct3 = f3; funct7 = f7; Zero = z;
        #1;
        snap(0);
        lat = 0; n_rw = 0; n_mw = 0; n_pcw = 0;
        do begin
            step();
            lat++;
            if (!IRWrite) begin
                snap(lat);
                if (RegWrite) n_rw++;
                if (MemWrite) n_mw++;
                if (PCWrite)  n_pcw++;
            end
        end while (!IRWrite && lat < 12);
        ret_exp++;
`ifdef INSTRET_COUNTER_EN
        check("instret", InstRet, ret_exp);
`endif
    endtask

    logic [6:0] t_op [5] = '{7'b0110011, 7'b0010011, 7'b0110011, 7'b0110011, 7'b0010011};
    logic [2:0] t_f3 [5] = '{3'b010, 3'b110, 3'b111, 3'b001, 3'b010};
    logic       t_f7 [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0] t_alc [5] = '{3'b101, 3'b011, 3'b010, 3'b000, 3'b101};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic any_strobe;
        n_checks = 0; n_bad = 0; ret_exp = 0;
        RESET = 1'b1; EN = 1'b1; OP = 7'b0; funct3 = 3'b0; funct7 = 1'b0; Zero = 1'b0;

        repeat (3) begin
            step();
            check("rst_irw", IRWrite, 0);
            check("rst_pcw", PCWrite, 0);
            check("rst_halt", Halted, 0);
        end
        RESET = 1'b0;
        #1;
        check("fetch_irw", IRWrite, 1);
        check("fetch_pcw", PCWrite, 1);
        check("fetch_srcb", ALUSrcB, 2'b10);
        check("fetch_res", ResultSrc, 2'b10);
`ifdef INSTRET_COUNTER_EN
        check("instret_rst", InstRet, 0);
`endif

        run_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
        check("add_lat", lat, 4);
        check("add_dec_sa", s_sa[1], 2'b01);
        check("add_dec_sb", s_sb[1], 2'b01);
        check("add_ex_sa", s_sa[2], 2'b10);
        check("add_ex_sb", s_sb[2], 2'b00);
        check("add_alc", s_alc[2], 3'b000);
        check("add_wb_rw", s_rw[3], 1);
        check("add_wb_res", s_rs[3], 2'b00);
        check("add_nrw", n_rw, 1);

        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
        check("sub_lat", lat, 4);
        check("sub_alc", s_alc[2], 3'b001);

        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
        check("lw_lat", lat, 5);
        check("lw_imm", ImmSrc, 2'b00);
        check("lw_adr_sa", s_sa[2], 2'b10);
        check("lw_adr_sb", s_sb[2], 2'b01);
        check("lw_rd_adr", s_adr[3], 1);
        check("lw_wb_res", s_rs[4], 2'b01);
        check("lw_wb_rw", s_rw[4], 1);
        check("lw_nrw", n_rw, 1);

        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
        check("sw_lat", lat, 4);
        check("sw_imm", ImmSrc, 2'b01);
        check("sw_mw", s_mw[3], 1);
        check("sw_adr", s_adr[3], 1);
        check("sw_nmw", n_mw, 1);
        check("sw_nrw", n_rw, 0);

        run_instr(7'b1100011, 3'b000, 1'b0, 1'b1);
        check("beq_lat", lat, 3);
        check("beq_imm", ImmSrc, 2'b10);
        check("beq_pcw", s_pcw[2], 1);
        check("beq_alc", s_alc[2], 3'b001);
        check("beq_npcw", n_pcw, 1);

        run_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
        check("jal_lat", lat, 4);
        check("jal_imm", ImmSrc, 2'b11);
        check("jal_pcw", s_pcw[2], 1);
        check("jal_sa", s_sa[2], 2'b01);
        check("jal_sb", s_sb[2], 2'b10);
        check("jal_wb_rw", s_rw[3], 1);

        run_instr(7'b1100011, 3'b000, 1'b0, 1'b0);
        check("beqnt_lat", lat, 3);
        check("beqnt_npcw", n_pcw, 0);

        run_instr(7'b0010011, 3'b000, 1'b1, 1'b0);
        check("addi_lat", lat, 4);
        check("addi_alc", s_alc[2], 3'b000);
        check("addi_sb", s_sb[2], 2'b01);

        for (int i = 0; i < 5; i++) begin
            run_instr(t_op[i], t_f3[i], t_f7[i], 1'b0);
            check($sformatf("alu%0d_lat", i), lat, 4);
            check($sformatf("alu%0d_alc", i), s_alc[2], t_alc[i]);
        end

        // Stall inside MEMWRITE: selects hold, the write strobe is suppressed.
        OP = 7'b0100011; funct3 = 3'b010; funct7 = 1'b0;
        step(); step(); step();
        EN = 1'b0;
        #1;
        repeat (3) begin
            step();
            check("stall_mw", MemWrite, 0);
            check("stall_adr", AdrSrc, 1);
            check("stall_irw", IRWrite, 0);
        end
`ifdef INSTRET_COUNTER_EN
        check("stall_instret", InstRet, ret_exp);
`endif
        EN = 1'b1;
        #1;
        check("resume_mw", MemWrite, 1);
        step();
        check("resume_fetch", IRWrite, 1);
        check("resume_mw_off", MemWrite, 0);
        ret_exp++;
`ifdef INSTRET_COUNTER_EN
        check("resume_instret", InstRet, ret_exp);
`endif

        // Reset in MEMREAD abandons the load.
        OP = 7'b0000011;
        step(); step(); step();
        check("mid_adr", AdrSrc, 1);
        RESET = 1'b1;
        #1;
        check("mid_rst_strobes", {PCWrite, IRWrite, MemWrite, RegWrite}, 4'b0000);
        check("mid_rst_adr", AdrSrc, 0);
        step();
        check("mid_rst_hold", {PCWrite, IRWrite, MemWrite, RegWrite}, 4'b0000);
        RESET = 1'b0;
        #1;
        check("mid_rel_irw", IRWrite, 1);
        ret_exp = 0;
`ifdef INSTRET_COUNTER_EN
        check("mid_instret", InstRet, 0);
`endif

        // Illegal opcode: halting instance parks, NOP instance returns to FETCH.
        OP = 7'b1111111;
        #1;
        step();
        check("ill_dec_halt", Halted, 0);
        step();
        check("ill_halted", Halted, 1);
        check("ill_nop_fetch", n_IRWrite, 1);
        check("ill_nop_halt", n_Halted, 0);
        any_strobe = 1'b0;
        repeat (10) begin
            step();
            any_strobe = any_strobe | PCWrite | IRWrite | MemWrite | RegWrite | ~Halted;
        end
        check("ill_quiet", any_strobe, 0);
`ifdef INSTRET_COUNTER_EN
        check("ill_instret", InstRet, 0);
        check("nop_instret", n_InstRet, 6);
`endif
        RESET = 1'b1;
        #1;
        check("ill_rst_halt", Halted, 0);
        step();
        RESET = 1'b0;
        #1;
        check("ill_rel_irw", IRWrite, 1);

        run_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
        check("post_add_lat", lat, 4);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
